// File: rtl/sequence_byte_serializer_pkg.sv
// Shared constants and the push-classification helper for the sequence byte serializer.
package sequence_byte_serializer_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Introducer byte that starts every ASCII control sequence from the generators.
  localparam logic [7:0] SEQ_INTRODUCER = 8'h1E;

  // Largest sequence the generators can present in one cycle.
  localparam int unsigned SEQ_MAX_BYTES = 4;

  typedef enum logic [1:0] {
    PushNone,
    PushAccept,
    PushDrop
  } push_e;

  // A sequence is taken whole or not at all; malformed counts are always dropped.
  function automatic push_e classify_push(input logic [2:0] count, input int unsigned free_bytes);
    if (count == 3'd0) begin
      return PushNone;
    end
    if ((32'(count) > SEQ_MAX_BYTES) || (32'(count) > free_bytes)) begin
      return PushDrop;
    end
    return PushAccept;
  endfunction

endpackage

// File: rtl/sequence_byte_serializer_fifo.sv
// Byte FIFO with atomic multi-byte write and single-byte first-word-fall-through read.
// The read-side byte and valid flag are registered so the consumer never sees a
// combinational path from the write port.
module byte_fifo_multiwrite
  import sequence_byte_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEVEL_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en_i,
  input  logic [2:0]                         wr_count_i,
  input  logic [SEQ_MAX_BYTES-1:0][7:0]      wr_bytes_i,
  input  logic                               rd_ready_i,
  output logic [7:0]                         rd_data_o,
  output logic                               rd_valid_o,
  output logic [LEVEL_WIDTH-1:0]             level_o
);

  localparam int unsigned PtrW = LEVEL_WIDTH - 1;

  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]        wr_idx;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [LEVEL_WIDTH-1:0] push_n;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   pop;

  // Next state: apply the write burst to a copy of memory so the output register
  // can pick up a byte written in the same cycle the FIFO leaves empty.
  always_comb begin
    mem_d  = mem_q;
    wr_idx = wr_ptr_q;
    push_n = wr_en_i ? LEVEL_WIDTH'(wr_count_i) : '0;
    for (int k = 0; k < SEQ_MAX_BYTES; k++) begin
      if (wr_en_i && (k < int'(wr_count_i))) begin
        wr_idx        = wr_ptr_q + PtrW'(k);
        mem_d[wr_idx] = wr_bytes_i[k];
      end
    end
    pop      = valid_q && rd_ready_i;
    wr_ptr_d = wr_ptr_q + PtrW'(push_n);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    level_d  = level_q + push_n - LEVEL_WIDTH'(pop);
    valid_d  = (level_d != '0);
    // Hold the last byte when empty; its value is not meaningful then.
    data_d   = valid_d ? mem_d[rd_ptr_d] : data_q;
  end

  // Storage array; contents need no reset because valid gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointers, level and registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign level_o    = level_q;

endmodule

// File: rtl/sequence_byte_serializer.sv
// Accepts count-qualified multi-byte sequences and streams them out one byte at a time.
// Sequences that do not fit, or carry a malformed count, are dropped whole and flagged.
module sequence_byte_serializer
  import sequence_byte_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEVEL_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            sequence_in,
  input  logic [2:0]             sequence_in_count,
  output logic [7:0]             byte_out,
  output logic                   byte_out_valid,
  input  logic                   byte_out_ready,
  output logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  logic [SEQ_MAX_BYTES-1:0][7:0] seq_bytes;
  logic [LEVEL_WIDTH-1:0]        free_bytes;
  push_e                         push_kind;
  logic                          overflow_q, overflow_d;

  // Decide accept/drop from the level at the start of the cycle; a same-cycle pop
  // deliberately does not free space.
  always_comb begin
    for (int k = 0; k < SEQ_MAX_BYTES; k++) begin
      seq_bytes[k] = sequence_in[8*k +: 8];
    end
    free_bytes = LEVEL_WIDTH'(FIFO_DEPTH) - fifo_level;
    push_kind  = classify_push(sequence_in_count, 32'(free_bytes));
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (push_kind == PushDrop) begin
      overflow_d = HIGH;
    end else if (clear_overflow) begin
      overflow_d = LOW;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= LOW;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  byte_fifo_multiwrite #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LEVEL_WIDTH (LEVEL_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (push_kind == PushAccept),
    .wr_count_i (sequence_in_count),
    .wr_bytes_i (seq_bytes),
    .rd_ready_i (byte_out_ready),
    .rd_data_o  (byte_out),
    .rd_valid_o (byte_out_valid),
    .level_o    (fifo_level)
  );

  assign overflow = overflow_q;

endmodule

// File: tb/tb_sequence_byte_serializer.sv
// Directed bench for sequence_byte_serializer: vector table plus hand-written
// multi-cycle sequences checked against a small queue model.
module tb_sequence_byte_serializer;

  logic        clk;
  logic        reset;
  logic [31:0] sequence_in;
  logic [2:0]  sequence_in_count;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  cnt;
    logic [31:0] seq;
    logic        rdy;
    logic        clr;
    logic        exp_valid;
    logic [7:0]  exp_byte;
    logic [4:0]  exp_level;
    logic        exp_ovf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] mq[$];
  logic       m_ovf;

  sequence_byte_serializer #(
    .FIFO_DEPTH  (16),
    .LEVEL_WIDTH (5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .sequence_in       (sequence_in),
    .sequence_in_count (sequence_in_count),
    .byte_out          (byte_out),
    .byte_out_valid    (byte_out_valid),
    .byte_out_ready    (byte_out_ready),
    .fifo_level        (fifo_level),
    .overflow          (overflow),
    .clear_overflow    (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cnt, input logic [31:0] seq, input logic rdy,
                              input logic clr, input logic ev, input logic [7:0] eb,
                              input logic [4:0] el, input logic eo);
    vec_t v;
    v.cnt = cnt; v.seq = seq; v.rdy = rdy; v.clr = clr;
    v.exp_valid = ev; v.exp_byte = eb; v.exp_level = el; v.exp_ovf = eo;
    return v;
  endfunction

  // One clock with inputs driven, then compare against the queue model.
  task automatic mstep(input string tag, input logic [2:0] cnt, input logic [31:0] seq,
                       input logic rdy, input logic clr);
    int  sz;
    bit  pop;
    bit  acc;
    sz  = mq.size();
    pop = (sz != 0) && rdy;
    acc = (cnt >= 1) && (cnt <= 4) && (int'(cnt) <= 16 - sz);
    if (pop) void'(mq.pop_front());
    if (acc) for (int k = 0; k < int'(cnt); k++) mq.push_back(seq[8*k +: 8]);
    if (cnt != 0 && !acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    sequence_in       = seq;
    sequence_in_count = cnt;
    byte_out_ready    = rdy;
    clear_overflow    = clr;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(byte_out_valid), 32'(mq.size() != 0));
    chk({tag, "_level"}, 32'(fifo_level), 32'(mq.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) chk({tag, "_byte"}, 32'(byte_out), 32'(mq[0]));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ovf  = 1'b0;
    reset             = 1'b1;
    sequence_in       = '0;
    sequence_in_count = '0;
    byte_out_ready    = 1'b0;
    clear_overflow    = 1'b0;

    // Single event
    vecs.push_back(mk(3'd4, 32'hA5C3811E, 1, 0, 1, 8'h1E, 5'd4, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h81, 5'd3, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'hC3, 5'd2, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'hA5, 5'd1, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 0, 8'h00, 5'd0, 0));
    // Backpressure: 4+2+3 bytes held, then released
    vecs.push_back(mk(3'd4, 32'h44332211, 0, 0, 1, 8'h11, 5'd4, 0));
    vecs.push_back(mk(3'd2, 32'h00006655, 0, 0, 1, 8'h11, 5'd6, 0));
    vecs.push_back(mk(3'd3, 32'h00998877, 0, 0, 1, 8'h11, 5'd9, 0));
    vecs.push_back(mk(3'd0, 32'h0, 0, 0, 1, 8'h11, 5'd9, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h22, 5'd8, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h33, 5'd7, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h44, 5'd6, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h55, 5'd5, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h66, 5'd4, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h77, 5'd3, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h88, 5'd2, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 1, 8'h99, 5'd1, 0));
    vecs.push_back(mk(3'd0, 32'h0, 1, 0, 0, 8'h00, 5'd0, 0));
    // Overflow and atomicity: fill to 14, drop a 4, fit a 2 exactly
    vecs.push_back(mk(3'd4, 32'h03020100, 0, 0, 1, 8'h00, 5'd4, 0));
    vecs.push_back(mk(3'd4, 32'h07060504, 0, 0, 1, 8'h00, 5'd8, 0));
    vecs.push_back(mk(3'd4, 32'h0B0A0908, 0, 0, 1, 8'h00, 5'd12, 0));
    vecs.push_back(mk(3'd2, 32'h00000D0C, 0, 0, 1, 8'h00, 5'd14, 0));
    vecs.push_back(mk(3'd4, 32'hDEADBEEF, 0, 0, 1, 8'h00, 5'd14, 1));
    vecs.push_back(mk(3'd2, 32'h00000F0E, 0, 0, 1, 8'h00, 5'd16, 1));
    vecs.push_back(mk(3'd1, 32'h000000AA, 0, 0, 1, 8'h00, 5'd16, 1));
    vecs.push_back(mk(3'd0, 32'h0, 0, 1, 1, 8'h00, 5'd16, 0));
    // Drop and clear together: set wins
    vecs.push_back(mk(3'd1, 32'h000000AA, 0, 1, 1, 8'h00, 5'd16, 1));
    vecs.push_back(mk(3'd0, 32'h0, 0, 1, 1, 8'h00, 5'd16, 0));
    // Full with a same-cycle pop: pop frees no space for this push
    vecs.push_back(mk(3'd1, 32'h000000BB, 1, 0, 1, 8'h01, 5'd15, 1));
    vecs.push_back(mk(3'd0, 32'h0, 0, 1, 1, 8'h01, 5'd15, 0));

    #2;
    chk("reset_valid", 32'(byte_out_valid), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_byte", 32'(byte_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      sequence_in       = vecs[i].seq;
      sequence_in_count = vecs[i].cnt;
      byte_out_ready    = vecs[i].rdy;
      clear_overflow    = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(byte_out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_byte", i), 32'(byte_out), 32'(vecs[i].exp_byte));
      end
    end

    // Hand the remaining contents (01..0F) to the model and drain across the wrap.
    for (int b = 1; b < 16; b++) mq.push_back(8'(b));
    m_ovf = 1'b0;
    for (int i = 0; i < 15; i++) mstep("drain", 3'd0, 32'h0, 1'b1, 1'b0);

    // Move both pointers to 14, then steady 4-byte pushes with ready high.
    mstep("align_push", 3'd1, 32'h00000077, 1'b1, 1'b0);
    mstep("align_pop", 3'd0, 32'h0, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      mstep("wrap_push", 3'd4, {8'(r), 8'hB0, 8'hA0 + 8'(r), 8'h1E}, 1'b1, 1'b0);
      for (int j = 0; j < 3; j++) mstep("wrap_idle", 3'd0, 32'h0, 1'b1, 1'b0);
    end
    for (int j = 0; j < 2; j++) mstep("wrap_tail", 3'd0, 32'h0, 1'b1, 1'b0);

    // Empty and malformed counts.
    for (int j = 0; j < 10; j++) mstep("idle", 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    mstep("malformed6", 3'd6, 32'h12345678, 1'b1, 1'b0);
    mstep("malformed_clr", 3'd0, 32'h0, 1'b1, 1'b1);
    mstep("malformed7", 3'd7, 32'h12345678, 1'b0, 1'b0);
    mstep("malformed_clr2", 3'd0, 32'h0, 1'b0, 1'b1);

    // Reset mid-stream between edges.
    mstep("rst_fill4", 3'd4, 32'h04030201, 1'b0, 1'b0);
    mstep("rst_fill3", 3'd3, 32'h00070605, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(byte_out_valid), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mstep("post_rst_push", 3'd1, 32'h0000005A, 1'b1, 1'b0);
    mstep("post_rst_pop", 3'd0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_byte_serializer.md
Name: sequence_byte_serializer

Overview:
- Downstream of the mouse/keyboard ASCII sequence generators: accepts multi-byte sequences (up to 4 bytes per cycle, count-qualified) and emits them one byte at a time over a valid/ready stream toward the host serial transmitter.
- Contains a byte FIFO with atomic multi-byte push, so a sequence is either stored whole or dropped whole; it is never split.

Parameters:
- FIFO_DEPTH, 16, byte capacity; power of two, minimum 8.
- LEVEL_WIDTH, 5, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sequence_in  input  32  packed sequence; byte 0 in [7:0] is sent first, byte 3 in [31:24] last.
- sequence_in_count  input  3  number of valid bytes in sequence_in, 0..4; 0 means no sequence this cycle.
- byte_out  output  8  byte at FIFO head.
- byte_out_valid  output  1  byte_out holds a byte.
- byte_out_ready  input  1  consumer accepts byte_out this cycle.
- fifo_level  output  LEVEL_WIDTH  bytes currently stored.
- overflow  output  1  sticky: a sequence was dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert) clears byte_out=0, byte_out_valid=0, fifo_level=0, overflow=0, and both pointers to 0. Release is synchronous to clk.
- Sampling: sequence_in/sequence_in_count are sampled every rising edge. Each cycle with count≠0 is a new sequence. No hold/ready on the input side, because the upstream block pulses for one cycle.
- Accept rule: free = FIFO_DEPTH − fifo_level, taken at the start of the cycle; a same-cycle pop does not count as free space. Accept iff 1 ≤ count ≤ 4 and count ≤ free.
  - On accept: write byte k (k=0..count−1) to mem[wr_ptr+k] with modulo-FIFO_DEPTH wrap, then wr_ptr += count.
  - Not accepted because count > free: nothing is written and overflow is set.
  - count 5..7: treated as malformed, nothing is written, overflow is set.
- Output: first-word-fall-through.
  - byte_out = mem[rd_ptr] while byte_out_valid=1; byte_out_valid = (fifo_level≠0).
  - A pop happens when byte_out_valid && byte_out_ready; then rd_ptr += 1 with wrap.
  - byte_out and byte_out_valid must be registered, i.e. glitch-free and not combinationally dependent on sequence_in.
- Latency: a sequence accepted at edge N into an empty FIFO gives byte_out_valid=1 with byte 0 after edge N (visible in cycle N+1). With byte_out_ready held high, bytes stream one per cycle: byte k appears in cycle N+1+k.
- Simultaneous push and pop: fifo_level_next = fifo_level + accepted_count − pop.
- byte_out_ready while byte_out_valid=0 is ignored; the level never underflows.
- Full: fifo_level=FIFO_DEPTH rejects any count≥1. Exactly-fitting sequences (count = free) are accepted.
- Pointer wrap: pointers are LEVEL_WIDTH−1 bits; a 4-byte write straddling the end of memory wraps correctly.
- overflow: set by any drop, cleared only by clear_overflow or reset. If a drop and clear_overflow occur in the same cycle, set wins.
- Reset mid-stream: all stored bytes are discarded and byte_out_valid drops immediately (asynchronously). No partial sequence survives.
- byte_out holds its last value when the FIFO empties. Consumers must not rely on that value.

Decomposition:
- HIGH/LOW and the 0x1E sequence-introducer constant stay in the shared constant.v include. Add SEQ_MAX_BYTES=4 there.
- One natural sub-module: byte_fifo_multiwrite. It holds the storage array, pointers, level, and multi-write/single-read logic. The top level holds the accept/overflow logic and unpacks sequence_in into bytes.

Test Plan:
- Single event: seq=0xA5C3811E, count=4, ready=1 → byte_out 1E,81,C3,A5 in cycles N+1..N+4; valid low from N+5; level back to 0.
- Backpressure: push counts 4,2,3 (9 bytes) with ready=0 → level=9, byte_out=byte 0 stable. Release ready → the 9 bytes emerge in order, one per cycle.
- Overflow/atomicity: fill to level 14, push count=4 → dropped, level stays 14, overflow=1; push count=2 → accepted, level 16. Pulse clear_overflow → overflow=0.
- Simultaneous push/pop with wrap: with rd_ptr=wr_ptr=14 and a steady 4-byte push every 4 cycles while ready=1 → no drops, order preserved across the index 15→0 boundary.
- Malformed/empty: count=0 for 10 cycles → no change; count=6 → nothing written, overflow=1.
- Reset mid-stream: level=7, assert reset between edges → byte_out_valid=0 and level=0 without waiting for an edge. After release, a new count=1 push emerges correctly.
